// File: rtl/sdram_frame_arbiter.sv
// Arbitrates refresh, HDMI write and display read bursts onto the SDRAM command port over a double-buffered frame store.
// Grant and command fields register one edge after a request is seen in IDLE; fields hold until cmd_ready, grant holds until burst_done.
module sdram_frame_arbiter #(
  parameter int FRAME_WORDS      = 786432,
  parameter int BURST_LEN        = 8,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        SDRAM_CLK,
  input  logic        reset,
  input  logic        wr_req,
  input  logic        rd_req,
  output logic        wr_gnt,
  output logic        rd_gnt,
  output logic        ref_gnt,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic        cmd_refresh,
  output logic [1:0]  SDRAM_bank,
  output logic [12:0] SDRAM_addr,
  output logic [9:0]  SDRAM_col,
  input  logic        burst_done,
  output logic        front_buf,
  output logic        frame_ready,
  output logic        ref_overrun
);

  localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] REF_ONE   = RW'(1);
  localparam logic [24:0]   FRAME_END = 25'(FRAME_WORDS);
  localparam logic [24:0]   BURST_INC = 25'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [23:0]   wr_ptr, rd_ptr;
  logic [24:0]   wr_inc, rd_inc;
  logic          wr_wrap, rd_wrap;
  logic          last_rw;          // 1 = last data burst was a write
  logic          ref_pend;
  logic [RW-1:0] ref_cnt;
  logic          ref_wrap;
  logic          take_ref, take_wr, take_rd;
  logic          done;

  assign wr_inc   = {1'b0, wr_ptr} + BURST_INC;
  assign rd_inc   = {1'b0, rd_ptr} + BURST_INC;
  assign wr_wrap  = (wr_inc == FRAME_END);
  assign rd_wrap  = (rd_inc == FRAME_END);
  assign ref_wrap = (ref_cnt == REF_LAST);
  assign done     = (state == BUSY) && burst_done;

  always_ff @(posedge SDRAM_CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_ref  = 1'b0;
    take_wr   = 1'b0;
    take_rd   = 1'b0;
    cmd_valid = (state == ISSUE);
    case (state)
      IDLE: begin
        if (ref_pend)                take_ref = 1'b1;
        else if (wr_req && rd_req) begin
          if (last_rw) take_rd = 1'b1;
          else         take_wr = 1'b1;
        end
        else if (wr_req)             take_wr = 1'b1;
        else if (rd_req)             take_rd = 1'b1;
        if (take_ref || take_wr || take_rd) state_nxt = ISSUE;
      end
      ISSUE:   if (cmd_ready)  state_nxt = BUSY;
      BUSY:    if (burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A refresh being issued on the wrap edge is serviced, so it does not count as an overrun.
  always_ff @(posedge SDRAM_CLK or posedge reset) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_ONE;
      if (ref_wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend && !take_ref) ref_overrun <= 1'b1;
      end else if (take_ref) begin
        ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge SDRAM_CLK or posedge reset) begin
    if (reset) begin
      wr_gnt      <= 1'b0;
      rd_gnt      <= 1'b0;
      ref_gnt     <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_refresh <= 1'b0;
      SDRAM_bank  <= '0;
      SDRAM_addr  <= '0;
      SDRAM_col   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_rw     <= 1'b1;
      front_buf   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      if (take_ref) begin
        ref_gnt     <= 1'b1;
        cmd_refresh <= 1'b1;
        cmd_write   <= 1'b0;
        SDRAM_bank  <= '0;
        SDRAM_addr  <= '0;
        SDRAM_col   <= '0;
      end
      if (take_wr) begin
        wr_gnt      <= 1'b1;
        last_rw     <= 1'b1;
        cmd_refresh <= 1'b0;
        cmd_write   <= 1'b1;
        SDRAM_bank  <= {~front_buf, wr_ptr[23]};
        SDRAM_addr  <= wr_ptr[22:10];
        SDRAM_col   <= wr_ptr[9:0];
      end
      if (take_rd) begin
        rd_gnt      <= 1'b1;
        last_rw     <= 1'b0;
        cmd_refresh <= 1'b0;
        cmd_write   <= 1'b0;
        SDRAM_bank  <= {front_buf, rd_ptr[23]};
        SDRAM_addr  <= rd_ptr[22:10];
        SDRAM_col   <= rd_ptr[9:0];
      end
      if (done) begin
        wr_gnt  <= 1'b0;
        rd_gnt  <= 1'b0;
        ref_gnt <= 1'b0;
        if (wr_gnt) begin
          wr_ptr <= wr_wrap ? '0 : wr_inc[23:0];
          if (wr_wrap) frame_ready <= 1'b1;
        end
        // Reader swaps buffers only at its own frame end and only if a fresh frame waits.
        if (rd_gnt) begin
          rd_ptr <= rd_wrap ? '0 : rd_inc[23:0];
          if (rd_wrap && frame_ready) begin
            front_buf   <= ~front_buf;
            frame_ready <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter with a 32-word frame so buffer swaps happen within a few bursts.
module tb_sdram_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0, cmd_ready = 1'b0, burst_done = 1'b0;
  logic        wr_gnt, rd_gnt, ref_gnt, cmd_valid, cmd_write, cmd_refresh;
  logic [1:0]  SDRAM_bank;
  logic [12:0] SDRAM_addr;
  logic [9:0]  SDRAM_col;
  logic        front_buf, frame_ready, ref_overrun;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] G_WR = 3'b100, G_RD = 3'b010, G_REF = 3'b001, G_NONE = 3'b000;

  sdram_frame_arbiter #(.FRAME_WORDS(32), .BURST_LEN(8), .REFRESH_INTERVAL(780)) dut (
    .SDRAM_CLK(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .ref_gnt(ref_gnt), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_refresh(cmd_refresh),
    .SDRAM_bank(SDRAM_bank), .SDRAM_addr(SDRAM_addr), .SDRAM_col(SDRAM_col),
    .burst_done(burst_done), .front_buf(front_buf), .frame_ready(frame_ready),
    .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {wr_gnt, rd_gnt, ref_gnt, cmd_valid, cmd_write, cmd_refresh, SDRAM_bank,
            SDRAM_addr, SDRAM_col, front_buf, frame_ready, ref_overrun};
  endfunction

  task automatic do_reset();
    wr_req = 1'b0; rd_req = 1'b0; burst_done = 1'b0; cmd_ready = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // One complete burst with cmd_ready high: issue edge, accept edge, done edge.
  task automatic do_burst(input string tag, input logic [2:0] g, input logic [1:0] bank,
                          input logic [9:0] col, input logic wr, input logic refr);
    step(1);
    check({tag, "_gnt"}, {29'd0, wr_gnt, rd_gnt, ref_gnt}, {29'd0, g});
    check({tag, "_vld"}, {31'd0, cmd_valid}, 32'd1);
    check({tag, "_fields"}, {5'd0, cmd_write, cmd_refresh, SDRAM_bank, SDRAM_addr, SDRAM_col},
          {5'd0, wr, refr, bank, 13'd0, col});
    step(1);
    check({tag, "_busy"}, {28'd0, wr_gnt, rd_gnt, ref_gnt, cmd_valid}, {28'd0, g, 1'b0});
    burst_done = 1'b1;
    step(1);
    burst_done = 1'b0;
    check({tag, "_idle"}, {28'd0, wr_gnt, rd_gnt, ref_gnt, cmd_valid}, 32'd0);
  endtask

  initial begin
    // Test 1: reset state and single writes
    do_reset();
    check("reset_outs", all_outs(), 32'd0);
    wr_req = 1'b1;
    do_burst("t1_wr0", G_WR, 2'b10, 10'd0, 1'b1, 1'b0);
    do_burst("t1_wr1", G_WR, 2'b10, 10'd8, 1'b1, 1'b0);
    wr_req = 1'b0;

    // Test 2: alternating arbitration, reads first after reset
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    do_burst("t2_rd0", G_RD, 2'b00, 10'd0, 1'b0, 1'b0);
    do_burst("t2_wr0", G_WR, 2'b10, 10'd0, 1'b1, 1'b0);
    do_burst("t2_rd1", G_RD, 2'b00, 10'd8, 1'b0, 1'b0);
    do_burst("t2_wr1", G_WR, 2'b10, 10'd8, 1'b1, 1'b0);
    wr_req = 1'b0; rd_req = 1'b0;

    // Test 4: fill frame, swap, next write targets buffer 0
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t4_wr", G_WR, 2'b10, 10'(i * 8), 1'b1, 1'b0);
    wr_req = 1'b0;
    check("t4_ready_set", {30'd0, front_buf, frame_ready}, 32'b01);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t4_rd", G_RD, 2'b00, 10'(i * 8), 1'b0, 1'b0);
    rd_req = 1'b0;
    check("t4_swapped", {30'd0, front_buf, frame_ready}, 32'b10);
    wr_req = 1'b1;
    do_burst("t4_wr_back", G_WR, 2'b00, 10'd0, 1'b1, 1'b0);
    wr_req = 1'b0;

    // Test 5: reader wrap without a ready frame, then writer double wrap
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t5_rd_a", G_RD, 2'b10, 10'(i * 8), 1'b0, 1'b0);
    rd_req = 1'b0;
    check("t5_no_swap", {30'd0, front_buf, frame_ready}, 32'b10);
    wr_req = 1'b1;
    for (int i = 1; i < 4; i++) do_burst("t5_wr_a", G_WR, 2'b00, 10'(i * 8), 1'b1, 1'b0);
    check("t5_ready1", {30'd0, front_buf, frame_ready}, 32'b11);
    for (int i = 0; i < 4; i++) do_burst("t5_wr_b", G_WR, 2'b00, 10'(i * 8), 1'b1, 1'b0);
    wr_req = 1'b0;
    check("t5_ready2", {30'd0, front_buf, frame_ready}, 32'b11);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t5_rd_b", G_RD, 2'b10, 10'(i * 8), 1'b0, 1'b0);
    check("t5_one_swap", {30'd0, front_buf, frame_ready}, 32'b00);
    for (int i = 0; i < 4; i++) do_burst("t5_rd_c", G_RD, 2'b00, 10'(i * 8), 1'b0, 1'b0);
    rd_req = 1'b0;
    check("t5_stay", {30'd0, front_buf, frame_ready}, 32'b00);

    // Test 3: refresh wins after wrap, then overrun with cmd_ready stuck low
    do_reset();
    rd_req = 1'b1;
    step(1);
    check("t3_rd_issue", {29'd0, wr_gnt, rd_gnt, ref_gnt}, {29'd0, G_RD});
    step(1);
    step(800);
    check("t3_no_overrun", {31'd0, ref_overrun}, 32'd0);
    check("t3_rd_held", {29'd0, wr_gnt, rd_gnt, ref_gnt}, {29'd0, G_RD});
    burst_done = 1'b1;
    step(1);
    burst_done = 1'b0;
    do_burst("t3_ref", G_REF, 2'b00, 10'd0, 1'b0, 1'b1);
    cmd_ready = 1'b0;
    step(1);
    check("t3_rd_after", {29'd0, wr_gnt, rd_gnt, ref_gnt}, {29'd0, G_RD});
    check("t3_rd_col", {22'd0, SDRAM_col}, 32'd8);
    step(400);
    check("t3_pre_overrun", {30'd0, cmd_valid, ref_overrun}, 32'b10);
    step(1200);
    check("t3_overrun", {30'd0, cmd_valid, ref_overrun}, 32'b11);
    check("t3_fields_stable", {9'd0, rd_gnt, cmd_refresh, SDRAM_bank, SDRAM_addr, SDRAM_col},
          {9'd0, 1'b1, 1'b0, 2'b00, 13'd0, 10'd8});

    // Test 6: reset during BUSY aborts everything
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t6_wr", G_WR, 2'b10, 10'(i * 8), 1'b1, 1'b0);
    wr_req = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) do_burst("t6_rd", G_RD, 2'b00, 10'(i * 8), 1'b0, 1'b0);
    rd_req = 1'b0;
    check("t6_front1", {31'd0, front_buf}, 32'd1);
    wr_req = 1'b1;
    step(2);
    check("t6_busy", {28'd0, wr_gnt, rd_gnt, ref_gnt, cmd_valid}, {28'd0, G_WR, 1'b0});
    cmd_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_async_clear", all_outs(), 32'd0);
    wr_req = 1'b0;
    step(1);
    reset = 1'b0;
    burst_done = 1'b1;
    step(1);
    burst_done = 1'b0;
    check("t6_done_ignored", all_outs(), 32'd0);
    cmd_ready = 1'b1; wr_req = 1'b1;
    do_burst("t6_wr_fresh", G_WR, 2'b10, 10'd0, 1'b1, 1'b0);
    wr_req = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_frame_arbiter.md
Name: sdram_frame_arbiter

Overview:
Sequences all accesses to the shared SDRAM frame store. It arbitrates burst requests from the HDMI pixel write path, the voxel display read path and a periodic refresh timer, and generates the bank/row/column address for each burst. Two frame buffers are managed so the display always reads a complete frame while HDMI fills the other one. Sits between the HDMI pixel FIFO, the display fetch logic and the SDRAM command/PHY layer.

Parameters:
FRAME_WORDS, 786432, words per frame (1024x768 24-bit pixels); must be a multiple of BURST_LEN and no more than 2^24.
BURST_LEN, 8, words moved per granted burst; pointer increment.
REFRESH_INTERVAL, 780, SDRAM_CLK cycles between refresh requests (7.8 us at 100 MHz).

Ports:
SDRAM_CLK  in  1  sole clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
wr_req  in  1  HDMI path has one burst of write data ready.
rd_req  in  1  display path has room for one burst.
wr_gnt  out  1  write burst granted; high from issue through burst_done.
rd_gnt  out  1  read burst granted; same timing as wr_gnt.
ref_gnt  out  1  refresh in progress; same timing.
cmd_valid  out  1  command fields are valid for the SDRAM controller.
cmd_ready  in  1  controller accepts the command this cycle.
cmd_write  out  1  1 means write burst, 0 means read or refresh.
cmd_refresh  out  1  1 means auto-refresh command.
SDRAM_bank  out  2  bank of burst start address.
SDRAM_addr  out  13  row of burst start address.
SDRAM_col  out  10  column of burst start address.
burst_done  in  1  controller has finished the current command.
front_buf  out  1  buffer currently being displayed; the writer targets the other buffer.
frame_ready  out  1  back buffer holds a complete frame that has not yet been swapped in.
ref_overrun  out  1  sticky; a refresh tick arrived while a refresh was still pending.

Behaviour:
- Reset: all outputs 0. wr_ptr = rd_ptr = 0, refresh counter = 0, refresh pending = 0, last_rw = WRITE, state = IDLE. Reset asserted mid-burst aborts the burst immediately; no completion is recorded.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE -> ISSUE when any request is pending; grant and command fields are registered on that edge.
  - ISSUE: cmd_valid = 1 and fields are held stable until cmd_ready. On cmd_ready, cmd_valid drops and the FSM moves to BUSY.
  - BUSY -> IDLE on burst_done; the grant deasserts on the same edge.
  - At least one IDLE cycle separates consecutive grants.
  - burst_done outside BUSY is ignored.
- Latency: a request visible in IDLE at edge N produces gnt = 1 and cmd_valid = 1 after edge N+1.
- Priority in IDLE:
  - Refresh pending wins over everything.
  - If both rd_req and wr_req are high, grant the one opposite to last_rw, then update last_rw.
  - If only one is high, grant it and update last_rw.
- Refresh timer:
  - Free-running counter 0..REFRESH_INTERVAL-1; it sets pending on wrap.
  - Pending clears when a refresh grant issues.
  - A wrap while pending is already set sets ref_overrun (cleared only by reset).
  - During refresh: cmd_refresh = 1, cmd_write = 0, bank/row/col = 0.
- Addressing (24-bit word pointer p = wr_ptr or rd_ptr):
  - SDRAM_col = p[9:0], SDRAM_addr = p[22:10], SDRAM_bank = {buf, p[23]}.
  - Writes use buf = ~front_buf; reads use buf = front_buf.
- Pointer update: on burst_done, the granted pointer advances by BURST_LEN. If the result equals FRAME_WORDS, it wraps to 0 (frame end).
- Writer frame end: frame_ready is set. If it is already set, it stays set; the back buffer was overwritten and the older frame is dropped.
- Reader frame end:
  - If frame_ready = 1, front_buf toggles and frame_ready clears on the same edge.
  - Otherwise the same buffer is re-displayed.
- Writer and reader frame ends cannot coincide, since only one burst completes per cycle.

Test Plan:
1. Reset, then a single wr_req with cmd_ready tied high -> wr_gnt and cmd_valid high after edge 1, cmd_write = 1, bank = 2'b10, row = 0, col = 0. After burst_done, wr_ptr = 8 and the next write shows col = 8.
2. rd_req and wr_req held high for 4 grants -> order is RD, WR, RD, WR, with exactly one IDLE cycle between grants.
3. Refresh timer wraps while rd_req is high -> ref_gnt is issued first with cmd_refresh = 1 and address 0; the read follows. Hold cmd_ready low for more than 780 cycles -> ref_overrun = 1.
4. FRAME_WORDS = 32: 4 write bursts -> frame_ready = 1. Then 4 read bursts -> front_buf goes 0->1 and frame_ready = 0. The next write uses bank[1] = 0.
5. Reader wraps with frame_ready = 0 -> front_buf unchanged. Writer wraps twice before any reader wrap -> frame_ready stays 1 and only one swap occurs.
6. Assert reset during BUSY with cmd_ready low -> all outputs 0 immediately, pointers 0, front_buf 0. A later burst_done pulse is ignored.
